// File: rtl/poly_pkg.sv
// Shared types and constants for the Poly-Play ROM download path.
package poly_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_READY = 2'd3
  } loader_state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_TNO = 8'd1;

  localparam int ROM_AW = 16;

endpackage

// File: rtl/poly_rom_loader.sv
// Converts the hps_io download stream into ROM write strobes for the
// Poly-Play core, captures the title number and sequences core reset.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no ROM loaded since reset; core held in reset
// ST_LOAD  | index-0 download active; bytes forwarded to the core ROM
// ST_HOLD  | download ended; core kept in reset for HOLD_CYCLES cycles
// ST_READY | ROM loaded and settled; core running
module poly_rom_loader
  import poly_pkg::*;
#(
  parameter int ROM_BYTES   = 65536,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              dn_wr,
  output logic [ROM_AW-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic [7:0]        tno,
  output logic              core_reset,
  output logic              rom_ok,
  output logic              overflow,
  output logic [16:0]       byte_count,
  output logic [15:0]       checksum
);

  localparam int          HCW       = $clog2(HOLD_CYCLES) + 1;
  localparam logic [16:0] COUNT_MAX = '1;

  loader_state_t  state;
  logic [HCW-1:0] hold_cnt;
  logic           dl_armed;

  logic rom_wr;
  logic in_range;
  logic start_load;

  assign rom_wr     = ioctl_wr && (ioctl_index == IDX_ROM);
  assign in_range   = ioctl_addr < 25'(ROM_BYTES);
  // A transfer already in flight when reset lifts must end before a new
  // download may start; dl_armed records that download has been seen low.
  assign start_load = dl_armed && ioctl_download && (ioctl_index == IDX_ROM);

  // Loader sequencing, ROM write strobes and diagnostic counters.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      dl_armed   <= 1'b0;
      dn_wr      <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= '0;
      core_reset <= 1'b1;
      rom_ok     <= 1'b0;
      overflow   <= 1'b0;
      byte_count <= '0;
      checksum   <= '0;
    end else begin
      dn_wr <= 1'b0;
      if (!ioctl_download) dl_armed <= 1'b1;

      case (state)
        ST_LOAD: begin
          if (rom_wr) begin
            if (in_range) begin
              dn_wr    <= 1'b1;
              dn_addr  <= ioctl_addr[ROM_AW-1:0];
              dn_data  <= ioctl_dout;
              checksum <= checksum + {8'd0, ioctl_dout};
              if (byte_count != COUNT_MAX) byte_count <= byte_count + 17'd1;
            end else begin
              overflow <= 1'b1;
            end
          end
          // A byte arriving on the same cycle download drops is still taken.
          if (!ioctl_download) begin
            state    <= ST_HOLD;
            hold_cnt <= HCW'(HOLD_CYCLES - 1);
          end
        end

        ST_IDLE, ST_READY, ST_HOLD: begin
          if (start_load) begin
            state      <= ST_LOAD;
            core_reset <= 1'b1;
            rom_ok     <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= '0;
            checksum   <= '0;
          end else if (state == ST_HOLD) begin
            if (hold_cnt == '0) begin
              state      <= ST_READY;
              core_reset <= 1'b0;
              rom_ok     <= !overflow;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Title number capture; independent of the loader state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tno <= '0;
    end else if (ioctl_wr && (ioctl_index == IDX_TNO)) begin
      tno <= ioctl_dout;
    end
  end

endmodule

// File: tb/tb_poly_rom_loader.sv
// Self-checking bench for poly_rom_loader: table vectors, directed
// corner sequences and randomized downloads against a behavioural model.
module tb_poly_rom_loader;

  localparam int HOLD = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dl;
  logic [7:0]  idx;
  logic        wr;
  logic [24:0] addr;
  logic [7:0]  dout;

  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [7:0]  tno;
  logic        core_reset;
  logic        rom_ok;
  logic        overflow;
  logic [16:0] byte_count;
  logic [15:0] checksum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  poly_rom_loader #(.ROM_BYTES(65536), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (dl),
    .ioctl_index    (idx),
    .ioctl_wr       (wr),
    .ioctl_addr     (addr),
    .ioctl_dout     (dout),
    .dn_wr          (dn_wr),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .tno            (tno),
    .core_reset     (core_reset),
    .rom_ok         (rom_ok),
    .overflow       (overflow),
    .byte_count     (byte_count),
    .checksum       (checksum)
  );

  // Behavioural model: tracks whether a ROM download is in progress and how
  // many settle cycles remain before the core may run.
  logic        m_dn_wr, m_cr, m_ok, m_ovf, m_loading, m_armed;
  logic [15:0] m_addr;
  logic [7:0]  m_data, m_tno;
  int          m_cnt, m_sum, m_hold_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dn_wr = 0; m_addr = 0; m_data = 0; m_tno = 0;
    m_cr = 1; m_ok = 0; m_ovf = 0; m_cnt = 0; m_sum = 0;
    m_loading = 0; m_hold_left = 0; m_armed = 0;
  endtask

  task automatic model_step();
    m_dn_wr = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (wr && idx == 8'd1) m_tno = dout;
    if (m_loading) begin
      if (wr && idx == 8'd0) begin
        if (addr < 25'd65536) begin
          m_dn_wr = 1;
          m_addr  = addr[15:0];
          m_data  = dout;
          if (m_cnt < 131071) m_cnt++;
          m_sum = (m_sum + int'(dout)) % 65536;
        end else begin
          m_ovf = 1;
        end
      end
      if (!dl) begin
        m_loading   = 0;
        m_hold_left = HOLD;
      end
    end else if (m_armed && dl && idx == 8'd0) begin
      m_loading = 1; m_hold_left = 0;
      m_cr = 1; m_ok = 0; m_ovf = 0; m_cnt = 0; m_sum = 0;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_cr = 0;
        m_ok = !m_ovf;
      end
    end
    if (!dl) m_armed = 1;
  endtask

  task automatic compare_all();
    chk("dn_wr",      32'(dn_wr),      32'(m_dn_wr));
    chk("dn_addr",    32'(dn_addr),    32'(m_addr));
    chk("dn_data",    32'(dn_data),    32'(m_data));
    chk("tno",        32'(tno),        32'(m_tno));
    chk("core_reset", 32'(core_reset), 32'(m_cr));
    chk("rom_ok",     32'(rom_ok),     32'(m_ok));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("byte_count", 32'(byte_count), 32'(m_cnt));
    chk("checksum",   32'(checksum),   32'(m_sum));
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
    compare_all();
  endtask

  // The download drop is sampled on the edge of the tick just taken; the
  // core must then come out of reset exactly HOLD edges later.
  task automatic wait_release(input string name);
    int n = 0;
    while (core_reset === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(name, 32'(n), 32'(HOLD));
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    wr = 1; addr = a; dout = d;
    tick();
    wr = 0;
  endtask

  typedef struct {
    logic        dl;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        e_dn_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    logic        e_cr;
    logic [16:0] e_cnt;
    logic [15:0] e_sum;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int seen;
    tbl[0] = '{1'b0, 1'b0, 25'h0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b1, 17'd0, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 25'h0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b1, 17'd0, 16'h0000};
    tbl[2] = '{1'b1, 1'b1, 25'h0, 8'h01, 1'b1, 16'h0000, 8'h01, 1'b1, 17'd1, 16'h0001};
    tbl[3] = '{1'b1, 1'b1, 25'h1, 8'h02, 1'b1, 16'h0001, 8'h02, 1'b1, 17'd2, 16'h0003};
    tbl[4] = '{1'b1, 1'b1, 25'h2, 8'hFF, 1'b1, 16'h0002, 8'hFF, 1'b1, 17'd3, 16'h0102};
    tbl[5] = '{1'b0, 1'b0, 25'h0, 8'h00, 1'b0, 16'h0002, 8'hFF, 1'b1, 17'd3, 16'h0102};

    reset_n = 1; dl = 0; idx = 0; wr = 0; addr = 0; dout = 0;
    #2 reset_n = 0;
    #1;
    model_reset();
    compare_all();
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys) reset_n = 1;

    // Idle after reset: core stays in reset, nothing is written.
    seen = 0;
    repeat (1000) begin
      tick();
      if (dn_wr) seen++;
    end
    chk("idle_no_dn_wr", 32'(seen), 32'd0);
    chk("idle_core_reset", 32'(core_reset), 32'd1);
    chk("idle_rom_ok", 32'(rom_ok), 32'd0);

    // Table: three back-to-back bytes, then download drops.
    idx = 8'd0;
    for (int i = 0; i < 6; i++) begin
      dl = tbl[i].dl; wr = tbl[i].wr; addr = tbl[i].addr; dout = tbl[i].dout;
      tick();
      chk($sformatf("vec%0d_dn_wr", i), 32'(dn_wr), 32'(tbl[i].e_dn_wr));
      if (tbl[i].e_dn_wr) begin
        chk($sformatf("vec%0d_dn_addr", i), 32'(dn_addr), 32'(tbl[i].e_addr));
        chk($sformatf("vec%0d_dn_data", i), 32'(dn_data), 32'(tbl[i].e_data));
      end
      chk($sformatf("vec%0d_core_reset", i), 32'(core_reset), 32'(tbl[i].e_cr));
      chk($sformatf("vec%0d_byte_count", i), 32'(byte_count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_checksum", i), 32'(checksum), 32'(tbl[i].e_sum));
    end
    wr = 0;
    wait_release("load_hold_len");
    chk("load_rom_ok", 32'(rom_ok), 32'd1);

    // Out-of-range byte plus the top in-range address.
    dl = 1; idx = 8'd0;
    tick();
    send_byte(25'h10000, 8'h55);
    chk("ovf_no_dn_wr", 32'(dn_wr), 32'd0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(byte_count), 32'd0);
    send_byte(25'h0FFFF, 8'h10);
    chk("top_addr_dn_wr", 32'(dn_wr), 32'd1);
    chk("top_addr_dn_addr", 32'(dn_addr), 32'hFFFF);
    dl = 0;
    tick();
    wait_release("ovf_hold_len");
    chk("ovf_rom_ok", 32'(rom_ok), 32'd0);
    chk("ovf_core_reset", 32'(core_reset), 32'd0);

    // Title number writes while running.
    seen = 0;
    dl = 1; idx = 8'd1;
    send_byte(25'h0, 8'h05); if (dn_wr) seen++;
    tick();                   if (dn_wr) seen++;
    send_byte(25'h0, 8'h03); if (dn_wr) seen++;
    dl = 0;
    tick();                   if (dn_wr) seen++;
    chk("tno_last", 32'(tno), 32'h03);
    chk("tno_core_reset", 32'(core_reset), 32'd0);
    chk("tno_no_dn_wr", 32'(seen), 32'd0);

    // New download five cycles into HOLD.
    dl = 1; idx = 8'd0;
    tick();
    send_byte(25'h40, 8'hA5);
    dl = 0;
    tick();
    repeat (5) tick();
    chk("hold_mid_core_reset", 32'(core_reset), 32'd1);
    dl = 1;
    tick();
    chk("restart_core_reset", 32'(core_reset), 32'd1);
    chk("restart_count", 32'(byte_count), 32'd0);
    chk("restart_sum", 32'(checksum), 32'd0);
    send_byte(25'h41, 8'h3C);
    dl = 0;
    tick();
    wait_release("restart_hold_len");

    // Reset mid-download after 100 bytes.
    dl = 1; idx = 8'd0;
    tick();
    for (int i = 0; i < 100; i++) send_byte(25'(i), 8'($urandom));
    #2 reset_n = 0;
    #1;
    model_reset();
    compare_all();
    chk("midreset_core_reset", 32'(core_reset), 32'd1);
    chk("midreset_count", 32'(byte_count), 32'd0);
    @(negedge clk_sys) reset_n = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      send_byte(25'(100 + i), 8'($urandom));
      if (dn_wr) seen++;
      tick();
    end
    chk("midreset_ignored", 32'(seen), 32'd0);
    chk("midreset_count_after", 32'(byte_count), 32'd0);
    dl = 0;
    tick();

    // Randomized downloads of every kind.
    for (int d = 0; d < 14; d++) begin
      int kind;
      int nbytes;
      kind = $urandom_range(0, 3);
      if (kind < 2) begin
        dl = 1; idx = (kind == 0) ? 8'd1 : 8'($urandom_range(2, 255));
        nbytes = $urandom_range(1, 4);
        for (int b = 0; b < nbytes; b++) begin
          send_byte(25'(b), 8'($urandom));
          tick();
        end
        dl = 0;
        tick();
      end else begin
        dl = 1; idx = 8'd0;
        tick();
        nbytes = $urandom_range(1, 40);
        for (int b = 0; b < nbytes; b++) begin
          repeat ($urandom_range(0, 2)) tick();
          if (b == nbytes - 1 && $urandom_range(0, 1) == 1) dl = 0;
          if ($urandom_range(0, 15) == 0)
            send_byte(25'(65536 + $urandom_range(0, 999)), 8'($urandom));
          else
            send_byte(25'($urandom_range(0, 65535)), 8'($urandom));
        end
        if (dl) begin
          dl = 0;
          tick();
        end
      end
      repeat ($urandom_range(0, 25)) tick();
    end
    repeat (HOLD + 4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
